// File: rtl/uart_pkg.sv
// uart_pkg: shared UART encodings, default frame width and majority helper
package uart_pkg;
    localparam int UART_DATA_WD = 8;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter with 2-of-3 mid-bit majority vote
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          rx,
    input  logic [PW-1:0] prescale,
    output logic          wrap,
    output logic          decide,
    output logic          sample
);
    logic [PW-1:0] edge_cnt;
    logic [PW-1:0] half;
    logic [1:0]    s;
    assign half = prescale >> 1;
    assign wrap = edge_cnt == prescale - PW'(1);
    assign decide = en && edge_cnt == half + PW'(1);
    assign sample = maj3(s[0], s[1], rx);
    // edge counter idles at 0 so the first START cycle is edge 0
    always_ff @(posedge clk or posedge rst)
        if (rst) edge_cnt <= '0;
        else edge_cnt <= (!en || wrap) ? '0 : edge_cnt + PW'(1);
    // capture the two samples ahead of the decision edge; the third is the live line
    always_ff @(posedge clk or posedge rst)
        if (rst) s <= 2'b11;
        else begin
            if (edge_cnt == half - PW'(1)) s[0] <= rx;
            if (edge_cnt == half) s[1] <= rx;
        end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity and stop check
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WD = UART_DATA_WD,
    parameter int PRESCALE_WD = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic [PRESCALE_WD-1:0] PRESCALE,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    output logic [DATA_WD-1:0]     P_DATA,
    output logic                   DATA_VALID,
    output logic                   PAR_ERR,
    output logic                   STP_ERR
);
    localparam int BW = $clog2(DATA_WD);
    rx_state_t state, next;
    logic rx_meta, rx_s;
    logic [PRESCALE_WD-1:0] prescale_r;
    logic par_en_r, par_typ_r, par_bad;
    logic [BW-1:0] bit_cnt;
    logic [DATA_WD-1:0] shreg;
    logic wrap, decide, sample, start, last, par_exp, stop_dec;
    assign start = state == IDLE && !rx_s;
    assign last = bit_cnt == BW'(DATA_WD - 1);
    assign par_exp = (par_typ_r == PAR_EVEN) ? ^shreg : ~^shreg;
    assign stop_dec = state == STOP && decide;
    uart_rx_sampler #(.PW(PRESCALE_WD)) u_sampler (
        .clk(CLK),
        .rst(RST),
        .en(state != IDLE),
        .rx(rx_s),
        .prescale(prescale_r),
        .wrap(wrap),
        .decide(decide),
        .sample(sample)
    );
    // two-flop synchronizer, idles high
    always_ff @(posedge CLK or posedge RST)
        if (RST) {rx_s, rx_meta} <= 2'b11;
        else {rx_s, rx_meta} <= {rx_meta, RX_IN};
    // state register
    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= IDLE;
        else state <= next;
    // next-state: stop decision returns to IDLE half a bit early for back-to-back frames
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (!rx_s) next = START;
            START:   if (decide && sample) next = IDLE;
                     else if (wrap) next = DATA;
            DATA:    if (wrap && last) next = par_en_r ? PARITY : STOP;
            PARITY:  if (wrap) next = STOP;
            STOP:    if (decide) next = IDLE;
            default: next = IDLE;
        endcase
    end
    // frame datapath: config latch, bit count, LSB-first shift, parity check
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            prescale_r <= '0;
            par_en_r <= 1'b0;
            par_typ_r <= 1'b0;
            par_bad <= 1'b0;
            bit_cnt <= '0;
            shreg <= '0;
        end else begin
            if (start) begin
                prescale_r <= PRESCALE;
                par_en_r <= PAR_EN;
                par_typ_r <= PAR_TYP;
                par_bad <= 1'b0;
                bit_cnt <= '0;
            end
            if (state == DATA && decide) shreg <= {sample, shreg[DATA_WD-1:1]};
            if (state == DATA && wrap) bit_cnt <= bit_cnt + BW'(1);
            if (state == PARITY && decide) par_bad <= sample != par_exp;
        end
    // completion pulses; stop error outranks parity error, only good frames load P_DATA
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            P_DATA <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR <= 1'b0;
            STP_ERR <= 1'b0;
        end else begin
            DATA_VALID <= stop_dec && sample && !par_bad;
            PAR_ERR <= stop_dec && sample && par_bad;
            STP_ERR <= stop_dec && !sample;
            if (stop_dec && sample && !par_bad) P_DATA <= shreg;
        end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed serial-BFM bench for uart_rx
module tb_uart_rx;
    logic CLK = 1'b0;
    logic RST, RX_IN, PAR_EN, PAR_TYP;
    logic [5:0] presc;
    logic [7:0] P_DATA;
    logic DATA_VALID, PAR_ERR, STP_ERR;
    int checks = 0;
    int errors = 0;
    int dv_n = 0;
    int pe_n = 0;
    int se_n = 0;
    int b_dv, b_pe, b_se;
    logic [7:0] dv_log [0:63];

    uart_rx dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .PRESCALE(presc),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_ERR(PAR_ERR),
        .STP_ERR(STP_ERR)
    );

    always #5 CLK = ~CLK;

    // count every output pulse cycle and log the byte presented with each DATA_VALID
    always @(negedge CLK) begin
        if (DATA_VALID) begin
            dv_log[dv_n[5:0]] = P_DATA;
            dv_n = dv_n + 1;
        end
        if (PAR_ERR) pe_n = pe_n + 1;
        if (STP_ERR) se_n = se_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_dv = dv_n;
        b_pe = pe_n;
        b_se = se_n;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    task automatic drive_bit(input logic v, input logic g);
        for (int i = 0; i < int'(presc); i++) begin
            @(negedge CLK);
            RX_IN = (g && i == int'(presc) / 2) ? ~v : v;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                              input logic sb, input logic g);
        drive_bit(1'b0, g);
        for (int i = 0; i < 8; i++) drive_bit(d[i], g);
        if (pe) drive_bit(pb, g);
        drive_bit(sb, g);
    endtask

    task automatic check_pulses(input string tag, input int dv, input int pe, input int se);
        check({tag, "_dv"}, dv_n - b_dv, dv);
        check({tag, "_pe"}, pe_n - b_pe, pe);
        check({tag, "_se"}, se_n - b_se, se);
    endtask

    initial begin
        RST = 1'b1;
        RX_IN = 1'b1;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        presc = 6'd8;
        repeat (3) @(negedge CLK);
        check("rst_pdata", P_DATA, 0);
        check("rst_dv", DATA_VALID, 0);
        check("rst_pe", PAR_ERR, 0);
        check("rst_se", STP_ERR, 0);
        RST = 1'b0;
        idle(10);

        snap();
        send_frame(8'hA3, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(16);
        check_pulses("t1", 1, 0, 0);
        check("t1_data", P_DATA, 8'hA3);

        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        snap();
        send_frame(8'hB4, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(16);
        check_pulses("t2", 1, 0, 0);
        check("t2_data", P_DATA, 8'hB4);

        PAR_TYP = 1'b1;
        snap();
        send_frame(8'hD2, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(16);
        check_pulses("t3", 0, 1, 0);
        check("t3_hold", P_DATA, 8'hB4);

        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(24);
        check_pulses("t4a", 0, 0, 1);
        check("t4a_hold", P_DATA, 8'hB4);
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(16);
        check_pulses("t4b", 1, 0, 0);
        check("t4b_data", P_DATA, 8'h3C);

        snap();
        @(negedge CLK);
        RX_IN = 1'b0;
        @(negedge CLK);
        idle(40);
        check_pulses("t5a", 0, 0, 0);
        snap();
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(16);
        check_pulses("t5b", 1, 0, 0);
        check("t5b_data", P_DATA, 8'h81);

        snap();
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b1 : 1'b0, 1'b0);
        repeat (2) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
        @(negedge CLK);
        RST = 1'b1;
        RX_IN = 1'b1;
        @(negedge CLK);
        check("t6_rst_pdata", P_DATA, 0);
        check("t6_rst_dv", DATA_VALID, 0);
        @(negedge CLK);
        RST = 1'b0;
        idle(30);
        check_pulses("t6a", 0, 0, 0);
        check("t6a_pdata", P_DATA, 0);

        presc = 6'd16;
        snap();
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(40);
        check_pulses("t6b", 2, 0, 0);
        check("t6b_first", dv_log[b_dv[5:0]], 8'h0F);
        check("t6b_second", dv_log[6'(b_dv + 1)], 8'hF0);
        check("t6b_data", P_DATA, 8'hF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
